// File: rtl/entry_sequencer.sv
// entry_sequencer: keypad front end for the calculator.
// Synchronises and debounces 16 raw buttons, accepts one keystroke per press,
// classifies it and acts as the single ordered writer of the operand RAM.
module entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 20800,
  parameter int MAX_DIGITS      = 3
) (
  input  logic        clk_i,
  input  logic        reset_n,
  input  logic [15:0] button,
  output logic        we,
  output logic [2:0]  adr,
  output logic [4:0]  value,
  output logic [2:0]  num_state,
  output logic        err,
  output logic        clr
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW = $clog2(MAX_DIGITS + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DIG_MAX = DW'(MAX_DIGITS);

  typedef enum logic [1:0] {S_RELEASED, S_ARMING, S_ACCEPT, S_HOLD} db_state_e;
  typedef enum logic [2:0] {PH_A = 3'd0, PH_OP = 3'd1, PH_B = 3'd2, PH_RES = 3'd3} phase_e;

  logic [15:0]   sync1_q, sync2_q, btn_s;
  db_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [15:0]   pat_q, pat_d;
  phase_e        phase_q, phase_d;
  logic [DW-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic          we_q, we_d, err_q, err_d, clr_q, clr_d;
  logic [2:0]    adr_q, adr_d, num_state_q, num_state_d;
  logic [4:0]    value_q, value_d;
  logic          btn_single_s, accept_s;
  logic [3:0]    key_idx_s;

  // Keystroke action candidates, applied only on the edge that enters ACCEPT
  logic          a_we_s, a_err_s, a_clr_s;
  logic [2:0]    a_adr_s;
  logic [4:0]    a_val_s;
  phase_e        a_phase_s;
  logic [DW-1:0] a_cnt_a_s, a_cnt_b_s;

  assign btn_s        = sync2_q;
  assign btn_single_s = (btn_s != 16'd0) && ((btn_s & (btn_s - 16'd1)) == 16'd0);
  assign cnt_inc_s    = cnt_q + CW'(1);

  // Two-flop synchroniser for the asynchronous button lines
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 16'd0;
      sync2_q <= 16'd0;
    end else begin
      sync1_q <= button;
      sync2_q <= sync1_q;
    end
  end

  // Index of the (single) set bit of the captured pattern
  always_comb begin
    key_idx_s = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (pat_q[i]) key_idx_s = 4'(i);
      else          key_idx_s = key_idx_s;
    end
  end

  // Decide what the current key would do in the current phase
  always_comb begin
    a_we_s    = 1'b0;
    a_err_s   = 1'b0;
    a_clr_s   = 1'b0;
    a_adr_s   = adr_q;
    a_val_s   = value_q;
    a_phase_s = phase_q;
    a_cnt_a_s = cnt_a_q;
    a_cnt_b_s = cnt_b_q;
    if (key_idx_s == 4'd15) begin
      a_clr_s   = 1'b1;
      a_phase_s = PH_A;
      a_cnt_a_s = '0;
      a_cnt_b_s = '0;
    end else if (phase_q == PH_RES) begin
      a_err_s = 1'b1;
    end else if (key_idx_s <= 4'd9) begin
      case (phase_q)
        PH_A: begin
          if (cnt_a_q < DIG_MAX) begin
            a_we_s    = 1'b1;
            a_adr_s   = 3'(cnt_a_q);
            a_val_s   = {1'b0, key_idx_s};
            a_cnt_a_s = cnt_a_q + DW'(1);
          end else begin
            a_err_s = 1'b1;
          end
        end
        PH_OP: begin
          a_we_s    = 1'b1;
          a_adr_s   = 3'd4;
          a_val_s   = {1'b0, key_idx_s};
          a_phase_s = PH_B;
          a_cnt_b_s = DW'(1);
        end
        PH_B: begin
          if (cnt_b_q < DIG_MAX) begin
            a_we_s    = 1'b1;
            a_adr_s   = 3'd4 + 3'(cnt_b_q);
            a_val_s   = {1'b0, key_idx_s};
            a_cnt_b_s = cnt_b_q + DW'(1);
          end else begin
            a_err_s = 1'b1;
          end
        end
        default: a_err_s = 1'b1;
      endcase
    end else if (key_idx_s <= 4'd13) begin
      // Operator: first one after operand A, or a change of operator
      if ((phase_q == PH_A && cnt_a_q != '0) || phase_q == PH_OP) begin
        a_we_s    = 1'b1;
        a_adr_s   = 3'd3;
        a_val_s   = 5'h10 + {1'b0, key_idx_s - 4'd10};
        a_phase_s = PH_OP;
      end else begin
        a_err_s = 1'b1;
      end
    end else begin
      // Equals needs at least one digit of operand B
      if (phase_q == PH_B && cnt_b_q != '0) a_phase_s = PH_RES;
      else                                  a_err_s   = 1'b1;
    end
  end

  // Debounce FSM next state and registered output selection
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pat_d       = pat_q;
    phase_d     = phase_q;
    cnt_a_d     = cnt_a_q;
    cnt_b_d     = cnt_b_q;
    we_d        = 1'b0;
    err_d       = 1'b0;
    clr_d       = 1'b0;
    adr_d       = adr_q;
    value_d     = value_q;
    num_state_d = num_state_q;
    accept_s    = 1'b0;
    case (state_q)
      S_RELEASED: begin
        cnt_d = '0;
        if (btn_s != 16'd0) begin
          state_d = S_ARMING;
          pat_d   = btn_s;
        end else begin
          state_d = S_RELEASED;
        end
      end
      S_ARMING: begin
        if (btn_s == 16'd0) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else if (!btn_single_s) begin
          state_d = S_HOLD;
          cnt_d   = '0;
        end else if (btn_s != pat_q) begin
          pat_d = btn_s;
          cnt_d = '0;
        end else if (cnt_inc_s == DB_LAST) begin
          state_d  = S_ACCEPT;
          cnt_d    = '0;
          accept_s = 1'b1;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      S_ACCEPT: begin
        // The phase becomes visible on the edge that drops the strobe
        state_d     = S_HOLD;
        cnt_d       = '0;
        num_state_d = 3'(phase_q);
      end
      S_HOLD: begin
        if (btn_s != 16'd0) begin
          cnt_d = '0;
        end else if (cnt_inc_s == DB_LAST) begin
          state_d = S_RELEASED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        state_d = S_RELEASED;
        cnt_d   = '0;
      end
    endcase
    if (accept_s) begin
      we_d    = a_we_s;
      err_d   = a_err_s;
      clr_d   = a_clr_s;
      adr_d   = a_adr_s;
      value_d = a_val_s;
      phase_d = a_phase_s;
      cnt_a_d = a_cnt_a_s;
      cnt_b_d = a_cnt_b_s;
    end else begin
      phase_d = phase_q;
    end
  end

  // State, counters and registered outputs
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_RELEASED;
      cnt_q       <= '0;
      pat_q       <= 16'd0;
      phase_q     <= PH_A;
      cnt_a_q     <= '0;
      cnt_b_q     <= '0;
      we_q        <= 1'b0;
      err_q       <= 1'b0;
      clr_q       <= 1'b0;
      adr_q       <= 3'd0;
      value_q     <= 5'd0;
      num_state_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pat_q       <= pat_d;
      phase_q     <= phase_d;
      cnt_a_q     <= cnt_a_d;
      cnt_b_q     <= cnt_b_d;
      we_q        <= we_d;
      err_q       <= err_d;
      clr_q       <= clr_d;
      adr_q       <= adr_d;
      value_q     <= value_d;
      num_state_q <= num_state_d;
    end
  end

  assign we        = we_q;
  assign err       = err_q;
  assign clr       = clr_q;
  assign adr       = adr_q;
  assign value     = value_q;
  assign num_state = num_state_q;

endmodule

// File: tb/tb_entry_sequencer.sv
// Bench for entry_sequencer: table of keystrokes with expected strobes,
// checked against a scoreboard queue by a pulse monitor.
module tb_entry_sequencer;

  localparam int D      = 4;
  localparam int K_NONE = 0;
  localparam int K_WE   = 1;
  localparam int K_ERR  = 2;
  localparam int K_CLR  = 3;

  logic        clk_i   = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] button  = 16'd0;
  logic        we, err, clr;
  logic [2:0]  adr, num_state;
  logic [4:0]  value;

  entry_sequencer #(.DEBOUNCE_CYCLES(D), .MAX_DIGITS(3)) dut (
    .clk_i     (clk_i),
    .reset_n   (reset_n),
    .button    (button),
    .we        (we),
    .adr       (adr),
    .value     (value),
    .num_state (num_state),
    .err       (err),
    .clr       (clr)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         kind;
    logic [2:0] adr;
    logic [4:0] val;
    logic [2:0] ph;
  } ev_t;

  typedef struct {
    int         key;
    int         kind;
    logic [2:0] adr;
    logic [4:0] val;
    logic [2:0] ph_after;
  } vec_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         mon_got;
  vec_t       tab[27];
  int         vectors     = 0;
  int         miscompares = 0;
  logic [2:0] cur_ph      = 3'd0;
  int         lat;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Pulse monitor: every strobe must match the oldest expected event
  always @(negedge clk_i) begin
    if (reset_n && (we || err || clr)) begin
      mon_got = we ? K_WE : (err ? K_ERR : K_CLR);
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_pulse: got we=%0b err=%0b clr=%0b adr=%0d value=%0h, required no pulse",
                 we, err, clr, adr, value);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_got != mon_e.kind || (int'(we) + int'(err) + int'(clr)) != 1 ||
            (mon_e.kind == K_WE && (adr != mon_e.adr || value != mon_e.val)) ||
            num_state != mon_e.ph) begin
          miscompares++;
          $display("FAIL pulse: got kind=%0d we=%0b err=%0b clr=%0b adr=%0d value=%0h ph=%0d, required kind=%0d adr=%0d value=%0h ph=%0d",
                   mon_got, we, err, clr, adr, value, num_state,
                   mon_e.kind, mon_e.adr, mon_e.val, mon_e.ph);
        end
      end
    end
  end

  task automatic do_vec(input vec_t v);
    if (v.kind != K_NONE) exp_q.push_back('{v.kind, v.adr, v.val, cur_ph});
    button = 16'd1 << v.key;
    repeat (12) @(negedge clk_i);
    button = 16'd0;
    repeat (12) @(negedge clk_i);
    check($sformatf("drained_key%0d", v.key), exp_q.size(), 0);
    exp_q.delete();
    check($sformatf("num_state_key%0d", v.key), int'(num_state), int'(v.ph_after));
    cur_ph = v.ph_after;
  endtask

  initial begin
    //          key kind    adr   val     phase after
    tab[0]  = '{15, K_CLR,  3'd0, 5'd0,   3'd0};
    tab[1]  = '{1,  K_WE,   3'd0, 5'd1,   3'd0};
    tab[2]  = '{2,  K_WE,   3'd1, 5'd2,   3'd0};
    tab[3]  = '{10, K_WE,   3'd3, 5'h10,  3'd1};
    tab[4]  = '{7,  K_WE,   3'd4, 5'd7,   3'd2};
    tab[5]  = '{14, K_NONE, 3'd0, 5'd0,   3'd3};
    tab[6]  = '{3,  K_ERR,  3'd0, 5'd0,   3'd3};
    tab[7]  = '{15, K_CLR,  3'd0, 5'd0,   3'd0};
    tab[8]  = '{4,  K_WE,   3'd0, 5'd4,   3'd0};
    tab[9]  = '{15, K_CLR,  3'd0, 5'd0,   3'd0};
    tab[10] = '{1,  K_WE,   3'd0, 5'd1,   3'd0};
    tab[11] = '{2,  K_WE,   3'd1, 5'd2,   3'd0};
    tab[12] = '{3,  K_WE,   3'd2, 5'd3,   3'd0};
    tab[13] = '{4,  K_ERR,  3'd0, 5'd0,   3'd0};
    tab[14] = '{15, K_CLR,  3'd0, 5'd0,   3'd0};
    tab[15] = '{11, K_ERR,  3'd0, 5'd0,   3'd0};
    tab[16] = '{9,  K_WE,   3'd0, 5'd9,   3'd0};
    tab[17] = '{13, K_WE,   3'd3, 5'h13,  3'd1};
    tab[18] = '{12, K_WE,   3'd3, 5'h12,  3'd1};
    tab[19] = '{14, K_ERR,  3'd0, 5'd0,   3'd1};
    tab[20] = '{6,  K_WE,   3'd4, 5'd6,   3'd2};
    tab[21] = '{5,  K_WE,   3'd5, 5'd5,   3'd2};
    tab[22] = '{8,  K_WE,   3'd6, 5'd8,   3'd2};
    tab[23] = '{0,  K_ERR,  3'd0, 5'd0,   3'd2};
    tab[24] = '{10, K_ERR,  3'd0, 5'd0,   3'd2};
    tab[25] = '{14, K_NONE, 3'd0, 5'd0,   3'd3};
    tab[26] = '{15, K_CLR,  3'd0, 5'd0,   3'd0};

    // Reset with button 5 held: outputs quiet, then one write after release
    reset_n = 1'b0;
    button  = 16'd1 << 5;
    repeat (3) @(negedge clk_i);
    check("rst_we", int'(we), 0);
    check("rst_err", int'(err), 0);
    check("rst_clr", int'(clr), 0);
    check("rst_adr", int'(adr), 0);
    check("rst_value", int'(value), 0);
    check("rst_num_state", int'(num_state), 0);
    exp_q.push_back('{K_WE, 3'd0, 5'd5, 3'd0});
    reset_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      if (we && lat == 0) lat = k;
    end
    check("accept_latency", lat, D + 3);
    button = 16'd0;
    repeat (12) @(negedge clk_i);
    check("drained_reset", exp_q.size(), 0);
    exp_q.delete();

    // Table of keystrokes
    for (int i = 0; i < 27; i++) do_vec(tab[i]);

    // Bounce on button 3, then a steady press writes exactly once
    for (int i = 0; i < 10; i++) begin
      button = (i % 2 == 0) ? (16'd1 << 3) : 16'd0;
      repeat (2) @(negedge clk_i);
    end
    do_vec('{3, K_WE, 3'd0, 5'd3, 3'd0});

    // Buttons 2 and 9 together: no action, then normal entry resumes
    button = (16'd1 << 2) | (16'd1 << 9);
    repeat (12) @(negedge clk_i);
    button = 16'd0;
    repeat (12) @(negedge clk_i);
    check("multi_num_state", int'(num_state), 0);
    do_vec('{7, K_WE, 3'd1, 5'd7, 3'd0});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
